// File: rtl/sad_blk_search.sv
// rtl/sad_blk_search.sv - row-streaming block SAD engine with running minimum search
module sad_blk_search #(
   parameter int DWIDTH     = 8,
   parameter int BLK_W      = 16,
   parameter int BLK_H      = 16,
   parameter int NUM_CAND   = 4,
   parameter int PIPE_STAGE = 2,
   localparam int SAD_W = DWIDTH + $clog2(BLK_W * BLK_H),
   localparam int RW    = (BLK_H > 1) ? $clog2(BLK_H) : 1,
   localparam int CW    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_vld,
   output logic                      in_rdy,
   input  logic [BLK_W*DWIDTH-1:0]   din,
   input  logic [BLK_W*DWIDTH-1:0]   refi,
   output logic [SAD_W-1:0]          sad,
   output logic [CW-1:0]             sad_idx,
   output logic                      sad_last,
   output logic [SAD_W-1:0]          best_sad,
   output logic [CW-1:0]             best_idx,
   output logic                      out_vld,
   input  logic                      out_rdy
);

   localparam int RSW = DWIDTH + $clog2(BLK_W);
   localparam int N   = PIPE_STAGE + 1;

   logic stall, accept;
   logic [RW-1:0] row_cnt_q, row_cnt_d;
   logic [CW-1:0] cand_cnt_q, cand_cnt_d;

   logic [DWIDTH-1:0] px_abs   [BLK_W];
   logic [DWIDTH-1:0] s0_abs_q [BLK_W];
   logic [DWIDTH-1:0] s0_abs_d [BLK_W];
   logic              s0_vld_q, s0_vld_d, s0_first_q, s0_first_d, s0_last_q, s0_last_d;
   logic [CW-1:0]     s0_idx_q, s0_idx_d;

   logic [RSW-1:0] row_sum;
   logic [RSW-1:0] dl_sum_q [N];
   logic [RSW-1:0] dl_sum_d [N];
   logic [CW-1:0]  dl_idx_q [N];
   logic [CW-1:0]  dl_idx_d [N];
   logic [N-1:0]   dl_vld_q, dl_vld_d, dl_first_q, dl_first_d, dl_last_q, dl_last_d;

   logic [SAD_W-1:0] acc_q, acc_d;
   logic             done_q, done_d;
   logic [CW-1:0]    done_idx_q, done_idx_d;

   logic [SAD_W-1:0] sad_q, sad_d, best_sad_q, best_sad_d;
   logic [CW-1:0]    sad_idx_q, sad_idx_d, best_idx_q, best_idx_d;
   logic             sad_last_q, sad_last_d, out_vld_q, out_vld_d;

   assign stall    = out_vld_q & ~out_rdy;
   assign in_rdy   = ~stall;
   assign accept   = in_vld & ~stall;
   assign sad      = sad_q;
   assign sad_idx  = sad_idx_q;
   assign sad_last = sad_last_q;
   assign best_sad = best_sad_q;
   assign best_idx = best_idx_q;
   assign out_vld  = out_vld_q;

   // One extra sign bit keeps the per-pixel difference exact before taking its magnitude.
   for (genvar i = 0; i < BLK_W; i++) begin : g_abs
      logic signed [DWIDTH:0] diff;
      assign diff      = $signed({1'b0, din[i*DWIDTH +: DWIDTH]}) - $signed({1'b0, refi[i*DWIDTH +: DWIDTH]});
      assign px_abs[i] = diff[DWIDTH] ? DWIDTH'(-diff) : DWIDTH'(diff);
   end

   always_comb begin
      row_cnt_d  = row_cnt_q;
      cand_cnt_d = cand_cnt_q;
      if (accept) begin
         if (row_cnt_q == RW'(BLK_H - 1)) begin
            row_cnt_d  = '0;
            cand_cnt_d = (cand_cnt_q == CW'(NUM_CAND - 1)) ? '0 : cand_cnt_q + 1'b1;
         end else begin
            row_cnt_d = row_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      s0_abs_d   = s0_abs_q;
      s0_vld_d   = s0_vld_q;
      s0_first_d = s0_first_q;
      s0_last_d  = s0_last_q;
      s0_idx_d   = s0_idx_q;
      if (!stall) begin
         s0_abs_d   = px_abs;
         s0_vld_d   = accept;
         s0_first_d = (row_cnt_q == '0);
         s0_last_d  = (row_cnt_q == RW'(BLK_H - 1));
         s0_idx_d   = cand_cnt_q;
      end
   end

   always_comb begin
      row_sum = '0;
      for (int i = 0; i < BLK_W; i++) begin
         row_sum = row_sum + RSW'(s0_abs_q[i]);
      end
   end

   // Slot 0 is the row-sum register; slots 1..PIPE_STAGE are pure delay.
   always_comb begin
      dl_sum_d   = dl_sum_q;
      dl_idx_d   = dl_idx_q;
      dl_vld_d   = dl_vld_q;
      dl_first_d = dl_first_q;
      dl_last_d  = dl_last_q;
      if (!stall) begin
         dl_sum_d[0]   = row_sum;
         dl_idx_d[0]   = s0_idx_q;
         dl_vld_d[0]   = s0_vld_q;
         dl_first_d[0] = s0_first_q;
         dl_last_d[0]  = s0_last_q;
         for (int k = 1; k < N; k++) begin
            dl_sum_d[k]   = dl_sum_q[k-1];
            dl_idx_d[k]   = dl_idx_q[k-1];
            dl_vld_d[k]   = dl_vld_q[k-1];
            dl_first_d[k] = dl_first_q[k-1];
            dl_last_d[k]  = dl_last_q[k-1];
         end
      end
   end

   always_comb begin
      acc_d      = acc_q;
      done_d     = done_q;
      done_idx_d = done_idx_q;
      if (!stall) begin
         done_d     = dl_vld_q[N-1] & dl_last_q[N-1];
         done_idx_d = dl_idx_q[N-1];
         if (dl_vld_q[N-1]) begin
            acc_d = dl_first_q[N-1] ? SAD_W'(dl_sum_q[N-1]) : acc_q + SAD_W'(dl_sum_q[N-1]);
         end
      end
   end

   always_comb begin
      out_vld_d  = out_vld_q;
      sad_d      = sad_q;
      sad_idx_d  = sad_idx_q;
      sad_last_d = sad_last_q;
      best_sad_d = best_sad_q;
      best_idx_d = best_idx_q;
      if (!stall) begin
         out_vld_d = done_q;
         if (done_q) begin
            sad_d      = acc_q;
            sad_idx_d  = done_idx_q;
            sad_last_d = (done_idx_q == CW'(NUM_CAND - 1));
            // Strict compare so a tie keeps the earlier candidate.
            if (done_idx_q == '0 || acc_q < best_sad_q) begin
               best_sad_d = acc_q;
               best_idx_d = done_idx_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt_q  <= '0;
         cand_cnt_q <= '0;
         s0_vld_q   <= 1'b0;
         s0_first_q <= 1'b0;
         s0_last_q  <= 1'b0;
         s0_idx_q   <= '0;
         dl_vld_q   <= '0;
         dl_first_q <= '0;
         dl_last_q  <= '0;
         acc_q      <= '0;
         done_q     <= 1'b0;
         done_idx_q <= '0;
         out_vld_q  <= 1'b0;
         sad_q      <= '0;
         sad_idx_q  <= '0;
         sad_last_q <= 1'b0;
         best_sad_q <= '0;
         best_idx_q <= '0;
      end else begin
         row_cnt_q  <= row_cnt_d;
         cand_cnt_q <= cand_cnt_d;
         s0_vld_q   <= s0_vld_d;
         s0_first_q <= s0_first_d;
         s0_last_q  <= s0_last_d;
         s0_idx_q   <= s0_idx_d;
         dl_vld_q   <= dl_vld_d;
         dl_first_q <= dl_first_d;
         dl_last_q  <= dl_last_d;
         acc_q      <= acc_d;
         done_q     <= done_d;
         done_idx_q <= done_idx_d;
         out_vld_q  <= out_vld_d;
         sad_q      <= sad_d;
         sad_idx_q  <= sad_idx_d;
         sad_last_q <= sad_last_d;
         best_sad_q <= best_sad_d;
         best_idx_q <= best_idx_d;
      end
   end

   always_ff @(posedge clk) begin
      s0_abs_q <= s0_abs_d;
      dl_sum_q <= dl_sum_d;
      dl_idx_q <= dl_idx_d;
   end

endmodule

// File: tb/tb_sad_blk_search.sv
// tb/tb_sad_blk_search.sv - self-checking bench for sad_blk_search
// Covers the default configuration and a small BLK_W=8/BLK_H=4/NUM_CAND=1/PIPE_STAGE=0 one.
module tb_sad_blk_search;
   localparam int D = 8, W = 16, H = 16, NC = 4, SW = 16;
   localparam int W2 = 8, H2 = 4, SW2 = 13;

   typedef struct {int sad; int idx; int last; int best; int bidx;} res_t;

   logic clk = 1'b0;
   logic rst, in_vld, out_rdy, in_vld2;
   logic out_rdy2 = 1'b1;
   logic [W*D-1:0]  din, refi;
   logic [W2*D-1:0] din2, refi2;
   logic            in_rdy, sad_last, out_vld;
   logic [SW-1:0]   sad, best_sad;
   logic [1:0]      sad_idx, best_idx;
   logic            in_rdy2, sad_last2, out_vld2;
   logic [SW2-1:0]  sad2, best_sad2;
   logic [0:0]      sad_idx2, best_idx2;

   int n_pass = 0, n_total = 0;
   int m_row = 0, m_cand = 0, m_acc = 0, m_best = 0, m_bidx = 0;
   int m2_row = 0, m2_acc = 0, got2_n = 0;
   int lat, bp_k;
   res_t exp_q[$];
   res_t e1;
   int exp2_q[$];
   int e2;
   int got_sad[$], got_idx[$], got_last[$], got_bsad[$], got_bidx[$];
   logic prev_stall = 1'b0;
   longint snap;

   sad_blk_search dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .din(din), .refi(refi),
      .sad(sad), .sad_idx(sad_idx), .sad_last(sad_last), .best_sad(best_sad),
      .best_idx(best_idx), .out_vld(out_vld), .out_rdy(out_rdy)
   );

   sad_blk_search #(.DWIDTH(8), .BLK_W(W2), .BLK_H(H2), .NUM_CAND(1), .PIPE_STAGE(0)) dut2 (
      .clk(clk), .rst(rst), .in_vld(in_vld2), .in_rdy(in_rdy2), .din(din2), .refi(refi2),
      .sad(sad2), .sad_idx(sad_idx2), .sad_last(sad_last2), .best_sad(best_sad2),
      .best_idx(best_idx2), .out_vld(out_vld2), .out_rdy(out_rdy2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int row_sad(input logic [W*D-1:0] a, input logic [W*D-1:0] b, input int n);
      int s = 0;
      for (int i = 0; i < n; i++) begin
         int x = int'(a[i*D +: D]) - int'(b[i*D +: D]);
         s += (x < 0) ? -x : x;
      end
      return s;
   endfunction

   function automatic logic [W*D-1:0] pix_row(input int t);
      logic [W*D-1:0] v = '0;
      int rem = t;
      for (int i = 0; i < W; i++) begin
         int p = (rem > 255) ? 255 : rem;
         v[i*D +: D] = D'(p);
         rem -= p;
      end
      return v;
   endfunction

   task automatic model_beat(input int rs);
      m_acc = (m_row == 0) ? rs : m_acc + rs;
      if (m_row == H - 1) begin
         if (m_cand == 0 || m_acc < m_best) begin
            m_best = m_acc;
            m_bidx = m_cand;
         end
         exp_q.push_back('{m_acc, m_cand, int'(m_cand == NC - 1), m_best, m_bidx});
         m_cand = (m_cand + 1) % NC;
      end
      m_row = (m_row + 1) % H;
   endtask

   task automatic send_row(input logic [W*D-1:0] d, input logic [W*D-1:0] r);
      int k = 0;
      din = d; refi = r; in_vld = 1'b1;
      @(negedge clk);
      while (!in_rdy && k < 200) begin
         k++;
         @(negedge clk);
      end
      if (!in_rdy) begin
         check("in_rdy_wait", longint'(in_rdy), 1);
         in_vld = 1'b0;
         return;
      end
      @(posedge clk);
      model_beat(row_sad(d, r, W));
      #1 in_vld = 1'b0;
   endtask

   task automatic send_blk(input int t);
      send_row(pix_row(t), '0);
      for (int r = 1; r < H; r++) send_row({W{8'h5A}}, {W{8'h5A}});
   endtask

   task automatic send_row2(input logic [W2*D-1:0] d, input logic [W2*D-1:0] r);
      din2 = d; refi2 = r; in_vld2 = 1'b1;
      @(posedge clk);
      if (in_rdy2) begin
         m2_acc = (m2_row == 0) ? row_sad({64'd0, d}, {64'd0, r}, W2) : m2_acc + row_sad({64'd0, d}, {64'd0, r}, W2);
         if (m2_row == H2 - 1) exp2_q.push_back(m2_acc);
         m2_row = (m2_row + 1) % H2;
      end else begin
         check("in_rdy2_accept", longint'(in_rdy2), 1);
      end
      #1 in_vld2 = 1'b0;
   endtask

   task automatic wait_results(input int n);
      int k = 0;
      while (got_sad.size() < n && k < 500) begin
         @(posedge clk);
         k++;
      end
      #1;
      check("result_count", got_sad.size(), n);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         check("in_rdy_vs_stall", longint'(in_rdy), longint'(!(out_vld && !out_rdy)));
         if (prev_stall) begin
            check("hold_vld", longint'(out_vld), 1);
            check("hold_out", longint'({sad, sad_idx, sad_last, best_sad, best_idx}), snap);
         end
         if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
               check("spurious_result", longint'(out_vld), 0);
            end else begin
               e1 = exp_q.pop_front();
               check("sad", longint'(sad), e1.sad);
               check("sad_idx", longint'(sad_idx), e1.idx);
               check("sad_last", longint'(sad_last), e1.last);
               check("best_sad", longint'(best_sad), e1.best);
               check("best_idx", longint'(best_idx), e1.bidx);
               got_sad.push_back(int'(sad));
               got_idx.push_back(int'(sad_idx));
               got_last.push_back(int'(sad_last));
               got_bsad.push_back(int'(best_sad));
               got_bidx.push_back(int'(best_idx));
            end
         end
         prev_stall = out_vld && !out_rdy;
         snap = longint'({sad, sad_idx, sad_last, best_sad, best_idx});
      end
   end

   always @(negedge clk) begin
      if (!rst && out_vld2) begin
         if (exp2_q.size() == 0) begin
            check("spurious_result2", longint'(out_vld2), 0);
         end else begin
            e2 = exp2_q.pop_front();
            check("sad2", longint'(sad2), e2);
            check("sad_idx2", longint'(sad_idx2), 0);
            check("sad_last2", longint'(sad_last2), 1);
            check("best_sad2", longint'(best_sad2), e2);
            check("best_idx2", longint'(best_idx2), 0);
            got2_n++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time %0t exceeded limit 500000", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_vld = 1'b0; in_vld2 = 1'b0; out_rdy = 1'b1;
      din = '0; refi = '0; din2 = '0; refi2 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_sad", longint'(sad), 0);
      check("rst_best", longint'(best_sad), 0);
      check("rst_out_vld", longint'(out_vld), 0);
      check("rst_in_rdy", longint'(in_rdy), 1);
      check("rst_out_vld2", longint'(out_vld2), 0);
      check("rst_in_rdy2", longint'(in_rdy2), 1);

      for (int r = 0; r < H; r++) send_row({W{8'd200}}, {W{8'd100}});
      lat = 0;
      while (!out_vld && lat < 50) begin
         @(posedge clk);
         #1 lat++;
      end
      check("latency", lat, 5);
      check("t1_sad", longint'(sad), 25600);
      check("t1_idx", longint'(sad_idx), 0);
      check("t1_best", longint'(best_sad), 25600);
      check("t1_bidx", longint'(best_idx), 0);

      send_row('0, {W{8'hFF}});
      for (int r = 1; r < H; r++) send_row({W{8'd7}}, {W{8'd7}});
      send_row({W{8'hFF}}, '0);
      for (int r = 1; r < H; r++) send_row({W{8'd7}}, {W{8'd7}});
      for (int r = 0; r < H; r++) send_row({W{8'hFF}}, '0);
      wait_results(4);
      check("sym_a", got_sad[1], 4080);
      check("sym_b", got_sad[2], 4080);
      check("max_sad", got_sad[3], 65280);
      check("max_last", got_last[3], 1);
      check("sym_best", got_bsad[3], 4080);
      check("sym_bidx", got_bidx[3], 1);

      send_blk(500); send_blk(120); send_blk(120); send_blk(900);
      wait_results(8);
      check("srch_bidx0", got_bidx[4], 0);
      check("srch_bidx1", got_bidx[5], 1);
      check("srch_bidx2", got_bidx[6], 1);
      check("srch_bidx3", got_bidx[7], 1);
      check("srch_sad1", got_sad[5], 120);
      check("srch_sad3", got_sad[7], 900);
      check("srch_best", got_bsad[7], 120);
      check("srch_last", got_last[7], 1);

      out_rdy = 1'b0;
      fork
         begin
            send_blk(300);
            send_blk(77);
         end
         begin
            bp_k = 0;
            while (!out_vld && bp_k < 200) begin
               @(negedge clk);
               bp_k++;
            end
            check("bp_vld", longint'(out_vld), 1);
            repeat (10) begin
               @(negedge clk);
               check("bp_in_rdy", longint'(in_rdy), 0);
            end
            @(posedge clk);
            #1 out_rdy = 1'b1;
         end
      join
      wait_results(10);
      check("bp_sad0", got_sad[8], 300);
      check("bp_sad1", got_sad[9], 77);
      check("bp_idx1", got_idx[9], 1);
      check("bp_best", got_bsad[9], 77);
      check("bp_bidx", got_bidx[9], 1);

      send_row(pix_row(50), '0);
      for (int r = 1; r < 8; r++) send_row({W{8'h5A}}, {W{8'h5A}});
      rst = 1'b1;
      @(posedge clk);
      m_row = 0; m_cand = 0; m_acc = 0;
      exp_q.delete();
      #1 rst = 1'b0;
      check("mid_rst_out_vld", longint'(out_vld), 0);
      check("mid_rst_sad", longint'(sad), 0);
      check("mid_rst_idx", longint'(sad_idx), 0);
      check("mid_rst_last", longint'(sad_last), 0);
      check("mid_rst_best", longint'(best_sad), 0);
      check("mid_rst_bidx", longint'(best_idx), 0);
      check("mid_rst_in_rdy", longint'(in_rdy), 1);
      send_blk(444);
      wait_results(11);
      check("post_rst_idx", got_idx[10], 0);
      check("post_rst_sad", got_sad[10], 444);
      check("post_rst_best", got_bsad[10], 444);

      for (int r = 0; r < H2; r++) send_row2({W2{8'hFF}}, '0);
      lat = 0;
      while (!out_vld2 && lat < 50) begin
         @(posedge clk);
         #1 lat++;
      end
      check("latency2", lat, 3);
      check("max_sad2", longint'(sad2), 8160);
      check("max_last2", longint'(sad_last2), 1);
      check("max_best2", longint'(best_sad2), 8160);
      for (int r = 0; r < H2; r++) send_row2({W2{8'd10}}, {W2{8'd30}});
      for (int r = 0; r < H2; r++) send_row2({W2{8'(r * 40)}}, {W2{8'd60}});
      lat = 0;
      while (got2_n < 3 && lat < 50) begin
         @(posedge clk);
         lat++;
      end
      #1;
      check("result_count2", got2_n, 3);
      check("model_pin_640", row_sad({64'd0, {W2{8'd10}}}, {64'd0, {W2{8'd30}}}, W2) * H2, 640);

      check("exp_q_drained", exp_q.size(), 0);
      check("exp2_q_drained", exp2_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sad_blk_search.md
Name: sad_blk_search

Overview:
- Parametrised, row-streaming SAD engine.
- Accepts one block row of current and reference pixels per handshake and accumulates BLK_H rows into one block SAD per candidate.
- Over a search of NUM_CAND consecutive candidates, tracks the minimum SAD and its candidate index.
- Sits between the reference-fetch buffer and the motion-decision logic.
- Replaces the single-shot 16x16 combinational SAD with a pipelined, back-pressured unit.

Parameters:
- DWIDTH, 8, pixel width in bits.
- BLK_W, 16, pixels per row (pixels per input beat).
- BLK_H, 16, rows per block. Must be at least 1.
- NUM_CAND, 4, candidates per search. Must be at least 1.
- PIPE_STAGE, 2, extra register stages inserted after the row adder tree. Must be at least 0.
- Derived, local: SAD_W = DWIDTH + clog2(BLK_W*BLK_H); RW = clog2(BLK_H) (minimum 1); CW = clog2(NUM_CAND) (minimum 1).

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_vld, input, 1, row beat valid.
- in_rdy, output, 1, row beat accepted when in_vld and in_rdy are both high.
- din, input, BLK_W*DWIDTH, current-block row; pixel i is din[i*DWIDTH +: DWIDTH].
- refi, input, BLK_W*DWIDTH, reference row; same pixel packing as din.
- sad, output, SAD_W, block SAD of the reported candidate.
- sad_idx, output, CW, candidate index of sad (0..NUM_CAND-1).
- sad_last, output, 1, high when sad_idx = NUM_CAND-1.
- best_sad, output, SAD_W, running minimum SAD, including the current result.
- best_idx, output, CW, index of best_sad.
- out_vld, output, 1, result valid.
- out_rdy, input, 1, result consumed when out_vld and out_rdy are both high.

Behaviour:
- Reset: every output register and counter clears at the first rising edge where rst=1.
  - Outputs sad, sad_idx, sad_last, best_sad, best_idx and out_vld reset to 0.
  - in_rdy resets to 1.
  - rst has priority over all other activity. Any partial block or search is discarded and the next accepted beat is row 0 of candidate 0.
- Stall: stall = out_vld & ~out_rdy. in_rdy = ~stall, combinational from out_rdy. While stall is high the whole pipeline holds state.
- Input counters: row_cnt and cand_cnt advance only on accepted beats.
  - row_cnt wraps from BLK_H-1 to 0, incrementing cand_cnt.
  - cand_cnt wraps from NUM_CAND-1 to 0.
  - Each beat carries first-row, last-row and candidate-index tags down the pipeline.
- Pipeline:
  - S0 registers per-pixel |din-refi|, computed on DWIDTH+1-bit signed differences.
  - S1 registers the row sum, width DWIDTH + clog2(BLK_W).
  - PIPE_STAGE delay stages follow.
  - The accumulator then loads the row sum on a first-row beat and adds it otherwise.
  - On a last-row beat, the final sum is written to sad with out_vld=1.
  - Latency: last row accepted at edge T gives out_vld=1 after edge T+3+PIPE_STAGE, with no stall.
  - Throughput is one row per cycle; back-to-back candidates need no gap.
- Arithmetic: no saturation is needed. The maximum SAD, (2^DWIDTH-1)*BLK_W*BLK_H, fits in SAD_W bits.
- Best tracking: updated in the same cycle sad is written.
  - Candidate index 0 loads best unconditionally.
  - Any other candidate replaces best only if sad < best_sad (strict). Ties keep the lower index.
  - best_sad and best_idx are valid whenever out_vld=1.
  - On sad_last=1, they hold the final search result.
- Output holding: sad, sad_idx, sad_last, best_sad and best_idx stay stable while out_vld=1 and out_rdy=0.
  - out_vld drops after the handshake edge unless a new result is written in the same cycle.
- BLK_H=1: every beat is both first and last row.
- NUM_CAND=1: every result has sad_last=1 and best equals sad.

Test Plan:
- Defaults, candidate 0: din all 8'd200, refi all 8'd100 for 16 rows, out_rdy=1. Expect out_vld exactly 5 cycles after the last beat; sad=25600, sad_idx=0, best_sad=25600, best_idx=0.
- Abs-value symmetry: one row with din=0 and refi=255 per pixel, other rows equal, then the inverse case. Both give sad=4080.
- Four-candidate search with SADs 500, 120, 120, 900. Expect best_idx sequence 0,1,1,1 and final best_sad=120 with sad_last=1 (tie keeps index 1).
- Backpressure: hold out_rdy=0 for 10 cycles while a result is pending and in_vld=1.
  - Expect in_rdy=0, outputs frozen and no beats lost.
  - After release, the next candidate result is correct.
- Reset mid-search: assert rst after row 7 of candidate 2 for one cycle.
  - Expect all outputs 0 and in_rdy=1.
  - A fresh 16-row block then reports sad_idx=0.
- Max-value check: din=255, refi=0 for all pixels, BLK_W=BLK_H=16. Expect sad=65280 with no overflow.
- Parameter sweep: BLK_W=8, BLK_H=4, NUM_CAND=1, PIPE_STAGE=0. Expect latency 3, sad_last always 1, SAD_W=13.
